// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Handles a req/ready memory, load-use stall, and decode redirects with a NOP flush.
module if_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        PC_IFWrite,
   input  logic        J,
   input  logic        JR,
   input  logic        Z,
   input  logic [31:0] JumpAddr,
   input  logic [31:0] JrAddr,
   input  logic [31:0] BranchAddr,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemReady,
   input  logic [31:0] IMemData,
   output logic [31:0] Instruction_id,
   output logic [31:0] NextPC_id
);

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_HOLD  = 2'd1,
      S_DRAIN = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] hold_q, hold_d;
   logic [XLEN-1:0] drain_q, drain_d;
   logic [XLEN-1:0] instr_q, instr_d;
   logic [XLEN-1:0] npc_q, npc_d;
   logic            req_q, req_d;
   logic [XLEN-1:0] addr_q, addr_d;

   logic            redir;
   logic            fetch_done;
   logic [XLEN-1:0] target;
   logic [XLEN-1:0] pc_plus4;

   // Decode operands are stale during a load-use stall, so redirects are masked by PC_IFWrite.
   assign redir      = PC_IFWrite & (JR | J | Z);
   assign target     = JR ? JrAddr : (J ? JumpAddr : BranchAddr);
   assign pc_plus4   = pc_q + PC_STEP;
   // Ready only counts against a request that is actually on the bus.
   assign fetch_done = req_q & IMemReady;

   // State and pipeline registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         hold_q  <= '0;
         drain_q <= '0;
         instr_q <= NOP;
         npc_q   <= '0;
         req_q   <= 1'b0;
         addr_q  <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         hold_q  <= hold_d;
         drain_q <= drain_d;
         instr_q <= instr_d;
         npc_q   <= npc_d;
         req_q   <= req_d;
         addr_q  <= addr_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      hold_d  = hold_q;
      drain_d = drain_q;
      instr_d = instr_q;
      npc_d   = npc_q;

      unique case (state_q)
         S_FETCH: begin
            if (redir && fetch_done) begin
               pc_d    = target;
               instr_d = NOP;
            end else if (redir) begin
               // An outstanding request must finish at its own address before the target is fetched.
               if (req_q) begin
                  drain_d = pc_q;
                  state_d = S_DRAIN;
               end
               pc_d    = target;
               instr_d = NOP;
            end else if (PC_IFWrite && fetch_done) begin
               instr_d = IMemData;
               npc_d   = pc_plus4;
               pc_d    = pc_plus4;
            end else if (PC_IFWrite) begin
               instr_d = NOP;
            end else if (fetch_done) begin
               hold_d  = IMemData;
               state_d = S_HOLD;
            end
         end

         S_HOLD: begin
            if (!PC_IFWrite) begin
               state_d = S_HOLD;
            end else if (redir) begin
               pc_d    = target;
               instr_d = NOP;
               state_d = S_FETCH;
            end else begin
               instr_d = hold_q;
               npc_d   = pc_plus4;
               pc_d    = pc_plus4;
               state_d = S_FETCH;
            end
         end

         S_DRAIN: begin
            if (PC_IFWrite) begin
               instr_d = NOP;
            end
            if (fetch_done) begin
               state_d = S_FETCH;
            end
         end

         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   // Memory-side outputs, registered from the next state so the address is stable per request
   always_comb begin
      req_d  = (state_d != S_HOLD);
      addr_d = (state_d == S_DRAIN) ? drain_d : pc_d;
   end

   assign IMemReq        = req_q;
   assign IMemAddr       = addr_q;
   assign Instruction_id = instr_q;
   assign NextPC_id      = npc_q;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: streamed fetches against a scoreboard,
// plus a vector table for stall, redirect, drain and wrap sequences.
module tb_if_stage;

   localparam logic [31:0] NOP = 32'h0000_0000;

   logic        clk;
   logic        rst_n;
   logic        PC_IFWrite;
   logic        J;
   logic        JR;
   logic        Z;
   logic [31:0] JumpAddr;
   logic [31:0] JrAddr;
   logic [31:0] BranchAddr;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemReady;
   logic [31:0] IMemData;
   logic [31:0] Instruction_id;
   logic [31:0] NextPC_id;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        pcw, j, jr, z, rdy;
      logic [31:0] jaddr, jraddr, baddr;
      logic [31:0] exp_instr;
      logic        chk_npc;
      logic [31:0] exp_npc;
      logic        exp_req;
      logic [31:0] exp_addr;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] npc;
   } id_t;

   vec_t        vecs[$];
   id_t         sb[$];
   logic [31:0] pc_m;

   if_stage #(.RESET_PC(32'h0000_0000), .NOP(NOP)) dut (
      .clk(clk), .rst_n(rst_n),
      .PC_IFWrite(PC_IFWrite), .J(J), .JR(JR), .Z(Z),
      .JumpAddr(JumpAddr), .JrAddr(JrAddr), .BranchAddr(BranchAddr),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemReady(IMemReady), .IMemData(IMemData),
      .Instruction_id(Instruction_id), .NextPC_id(NextPC_id)
   );

   function automatic logic [31:0] rom(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]};
   endfunction

   assign IMemData = rom(IMemAddr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input logic pcw, input logic j, input logic jr, input logic z,
                       input logic rdy, input logic [31:0] ja, input logic [31:0] jra,
                       input logic [31:0] ba);
      PC_IFWrite = pcw; J = j; JR = jr; Z = z; IMemReady = rdy;
      JumpAddr = ja; JrAddr = jra; BranchAddr = ba;
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic vec_t mk(input logic pcw, input logic j, input logic jr, input logic z,
                               input logic rdy, input logic [31:0] ja, input logic [31:0] jra,
                               input logic [31:0] ba, input logic [31:0] ei, input logic cn,
                               input logic [31:0] en, input logic er, input logic [31:0] ea);
      vec_t v;
      v.pcw = pcw; v.j = j; v.jr = jr; v.z = z; v.rdy = rdy;
      v.jaddr = ja; v.jraddr = jra; v.baddr = ba;
      v.exp_instr = ei; v.chk_npc = cn; v.exp_npc = en; v.exp_req = er; v.exp_addr = ea;
      return v;
   endfunction

   // Streams n instructions with a fixed number of wait cycles; expected IF/ID pushed at each handshake.
   task automatic run_stream(input int n, input int waits);
      int  done  = 0;
      int  wcnt  = 0;
      int  guard = 0;
      logic rdy;
      id_t e;
      while (done < n && guard < 200) begin
         chk("stream_req", 32'(IMemReq), 32'd1);
         chk("stream_addr", IMemAddr, pc_m);
         rdy = (wcnt >= waits);
         if (rdy) begin
            e.instr = rom(pc_m);
            e.npc   = pc_m + 32'd4;
            sb.push_back(e);
            pc_m = pc_m + 32'd4;
            wcnt = 0;
            done++;
         end else begin
            wcnt++;
         end
         step(1'b1, 1'b0, 1'b0, 1'b0, rdy, '0, '0, '0);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stream_instr", Instruction_id, e.instr);
            chk("stream_npc", NextPC_id, e.npc);
         end else begin
            chk("stream_bubble", Instruction_id, NOP);
         end
         guard++;
      end
      if (guard >= 200) begin
         chk("stream_timeout", 32'(done), 32'(n));
      end
   endtask

   initial begin
      rst_n = 1'b0;
      PC_IFWrite = 1'b1; J = 1'b0; JR = 1'b0; Z = 1'b0; IMemReady = 1'b0;
      JumpAddr = '0; JrAddr = '0; BranchAddr = '0;

      // Stall into HOLD with the fetch completing on the first stalled cycle; Z is masked.
      vecs.push_back(mk(0,0,0,0,1, 0,0,0,     32'h1000_000B,1,32'd48,  0,32'd48));
      vecs.push_back(mk(0,0,0,0,0, 0,0,0,     32'h1000_000B,1,32'd48,  0,32'd48));
      vecs.push_back(mk(0,0,0,1,0, 0,0,'hC0,  32'h1000_000B,1,32'd48,  0,32'd48));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,     32'h1000_000C,1,32'd52,  1,32'd52));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h1000_000D,1,32'd56,  1,32'd56));
      // Stall in FETCH with Z set: no flush, PC unchanged.
      vecs.push_back(mk(0,0,0,1,0, 0,0,'hC0,  32'h1000_000D,1,32'd56,  1,32'd56));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h1000_000E,1,32'd60,  1,32'd60));
      // Jump to 8, then J/JR/Z all set: JR wins.
      vecs.push_back(mk(1,1,0,0,1, 8,0,0,     NOP,0,0,                 1,32'h8));
      vecs.push_back(mk(1,1,1,1,1, 'h80,'h40,'hC0, NOP,0,0,            1,32'h40));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h1000_0010,1,32'h44,  1,32'h44));
      // Back to 8, then J and Z: J wins.
      vecs.push_back(mk(1,1,0,0,1, 8,0,0,     NOP,0,0,                 1,32'h8));
      vecs.push_back(mk(1,1,0,1,1, 'h80,0,'hC0, NOP,0,0,               1,32'h80));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h1000_0020,1,32'h84,  1,32'h84));
      // Branch alone.
      vecs.push_back(mk(1,0,0,1,1, 0,0,'hC0,  NOP,0,0,                 1,32'hC0));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h1000_0030,1,32'hC4,  1,32'hC4));
      // Redirect while the fetch at 0x20 is still waiting: drain, then fetch 0x100; J in DRAIN ignored.
      vecs.push_back(mk(1,1,0,0,1, 'h20,0,0,  NOP,0,0,                 1,32'h20));
      vecs.push_back(mk(1,0,0,1,0, 0,0,'h100, NOP,0,0,                 1,32'h20));
      vecs.push_back(mk(0,0,0,0,0, 0,0,0,     NOP,0,0,                 1,32'h20));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,     NOP,0,0,                 1,32'h20));
      vecs.push_back(mk(1,1,0,0,1, 'h200,0,0, NOP,0,0,                 1,32'h100));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h1000_0040,1,32'h104, 1,32'h104));
      // Redirect out of HOLD discards the buffered word.
      vecs.push_back(mk(0,0,0,0,1, 0,0,0,     32'h1000_0040,1,32'h104, 0,32'h104));
      vecs.push_back(mk(1,0,1,0,0, 0,'h300,0, NOP,0,0,                 1,32'h300));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h1000_00C0,1,32'h304, 1,32'h304));
      // PC+4 wraps to zero.
      vecs.push_back(mk(1,1,0,0,1, 32'hFFFF_FFFC,0,0, NOP,0,0,         1,32'hFFFF_FFFC));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h4FFF_FFFF,1,32'h0,   1,32'h0));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h1000_0000,1,32'h4,   1,32'h4));
      vecs.push_back(mk(1,0,0,0,0, 0,0,0,     NOP,0,0,                 1,32'h4));
      vecs.push_back(mk(1,0,0,0,1, 0,0,0,     32'h1000_0001,1,32'h8,   1,32'h8));

      repeat (2) @(negedge clk);
      chk("reset_instr", Instruction_id, NOP);
      chk("reset_npc", NextPC_id, 32'h0);
      chk("reset_req", 32'(IMemReq), 32'd0);
      chk("reset_addr", IMemAddr, 32'h0);

      rst_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("first_req", 32'(IMemReq), 32'd1);
      chk("first_addr", IMemAddr, 32'h0);
      chk("first_instr", Instruction_id, NOP);

      pc_m = 32'h0;
      run_stream(8, 0);
      run_stream(4, 2);

      foreach (vecs[i]) begin
         step(vecs[i].pcw, vecs[i].j, vecs[i].jr, vecs[i].z, vecs[i].rdy,
              vecs[i].jaddr, vecs[i].jraddr, vecs[i].baddr);
         chk($sformatf("vec%0d_instr", i), Instruction_id, vecs[i].exp_instr);
         if (vecs[i].chk_npc) chk($sformatf("vec%0d_npc", i), NextPC_id, vecs[i].exp_npc);
         chk($sformatf("vec%0d_req", i), 32'(IMemReq), 32'(vecs[i].exp_req));
         chk($sformatf("vec%0d_addr", i), IMemAddr, vecs[i].exp_addr);
      end

      pc_m = 32'h8;
      run_stream(3, 1);

      // Async reset while draining returns straight to the reset state.
      step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0, '0, 32'h500);
      chk("drain_req", 32'(IMemReq), 32'd1);
      chk("drain_addr", IMemAddr, 32'd20);
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_req", 32'(IMemReq), 32'd0);
      chk("midrst_addr", IMemAddr, 32'h0);
      chk("midrst_instr", Instruction_id, NOP);
      chk("midrst_npc", NextPC_id, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      IMemReady = 1'b0; Z = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("rerst_req", 32'(IMemReq), 32'd1);
      chk("rerst_addr", IMemAddr, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
